tick_period_monitor: RTL and testbench
======================================

Name: tick_period_monitor

Overview:
- Downstream consumer of the periodic one-cycle tick produced by the free-running delay/timer stage.
- Checks that successive ticks arrive at the nominal spacing, within a tolerance window.
- Acquires lock, flags early and late or missing ticks, counts errors, and declares a fault after repeated misses.
- Supervision results go to the error/status logic downstream.

Parameters:
- PERIOD, 1251: nominal tick-to-tick spacing in clk cycles.
- TOL, 2: allowed deviation, ± cycles.
- CBITS, 12: interval counter width; must hold PERIOD+TOL+1.
- LOCK_CNT, 3: consecutive good intervals required to lock.
- FAULT_CNT, 2: consecutive errors while locked that force FAULT.
- ECBITS, 8: error counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- tick, input, 1: one-cycle tick pulse from the upstream timer.
- locked, output, 1: high in LOCKED.
- fault, output, 1: high in FAULT.
- early, output, 1: one-cycle pulse, early tick detected while locked.
- late, output, 1: one-cycle pulse, late or missing tick detected while locked.
- err_cnt, output, ECBITS: saturating count of early and late events while locked.
- last_period, output, CBITS: measured interval D of the most recent classified tick.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ival, good_run, bad_run and resync all 0.
  - All outputs 0.
- Interval counter ival:
  - In a cycle with tick=1: D = ival+1 is captured and ival<=0.
  - Otherwise ival increments, saturating at 2^CBITS-1.
  - Back-to-back ticks give D=1.
- Classification of a tick with resync=0:
  - good: PERIOD-TOL ≤ D ≤ PERIOD+TOL.
  - early: D < PERIOD-TOL.
  - late: D = PERIOD+TOL+1.
  - A classified tick updates last_period<=D. Unclassified ticks leave last_period unchanged.
- Miss event:
  - Fires when tick=0 and ival==PERIOD+TOL (not checked in IDLE).
  - ival<=TOL+1, re-arming one nominal period later, and resync<=1.
  - A tick in that same cycle takes precedence: it is a late tick, with no miss and no re-arm.
- Resync tick:
  - A tick with resync=1 is not classified.
  - It sets ival<=0 and resync<=0, and leaves good_run and bad_run unchanged.
- States:
  - IDLE:
    - Tick: go to ACQ, good_run=0, first tick unclassified.
    - Miss detection disabled.
  - ACQ:
    - Good tick: good_run++. When good_run reaches LOCK_CNT, go to LOCKED with bad_run=0.
    - Early tick, late tick or miss: good_run=0.
    - No pulses; err_cnt unchanged.
  - LOCKED:
    - Good tick: bad_run=0.
    - Early tick: early pulse, err_cnt+1 (saturating), bad_run++.
    - Late tick or miss: late pulse, err_cnt+1 (saturating), bad_run++.
    - When bad_run reaches FAULT_CNT, go to FAULT.
  - FAULT:
    - Any tick: go to ACQ, good_run=0; that tick is treated as resync (ival<=0).
    - Misses are ignored (re-arm still occurs).
    - err_cnt retained.
- Output timing:
  - All outputs are registered.
  - early/late are asserted the cycle after the triggering clk edge and last exactly one cycle.
  - locked/fault track state, becoming valid one cycle after the transition edge.
- err_cnt is cleared only by reset.

Test Plan:
- Release reset; ticks spaced 1251 cycles, 5 ticks → locked=1 one cycle after 4th tick; err_cnt=0; last_period=1251; no early/late pulses.
- Locked; next tick at D=1240 → early one cycle, err_cnt=1, locked stays 1; following tick at 1251 → bad_run cleared, no pulse.
- Locked; tick at D=1253 → good, no pulse. Next tick at D=1254 → late pulse (tick precedence), err_cnt+1, last_period=1254.
- Locked; ticks stop → late pulse 1254 cycles after last tick, second late 1251 cycles later; fault=1, locked=0, err_cnt=2. Ticks resume at 1251 → fault=0 after first tick; locked=1 after 3 further good intervals.
- Locked; two ticks back-to-back (D=1) → early, then early again; FAULT after second; err_cnt=2.
- Locked, mid-interval; assert rst low asynchronously → all outputs 0 immediately without clk; after release, state IDLE and first tick does not update last_period.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Supervises the spacing of a periodic one-cycle tick: acquires lock, flags
// early/late/missing ticks while locked, counts errors and declares FAULT.
module tick_period_monitor #(
  parameter int PERIOD    = 1251,
  parameter int TOL       = 2,
  parameter int CBITS     = 12,
  parameter int LOCK_CNT  = 3,
  parameter int FAULT_CNT = 2,
  parameter int ECBITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic              locked,
  output logic              fault,
  output logic              early,
  output logic              late,
  output logic [ECBITS-1:0] err_cnt,
  output logic [CBITS-1:0]  last_period
);

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam int BBITS = $clog2(FAULT_CNT + 1);

  localparam logic [CBITS-1:0] IVAL_MAX = '1;
  localparam logic [CBITS-1:0] D_LO     = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] D_HI     = CBITS'(PERIOD + TOL);
  // After a miss, restart counting as if the missed tick had been on time.
  localparam logic [CBITS-1:0] REARM    = CBITS'(TOL + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CBITS-1:0]   ival;
  logic [GBITS-1:0]   good_run, good_next;
  logic [BBITS-1:0]   bad_run, bad_next;
  logic               resync;

  logic [CBITS-1:0]   d;
  logic               classify;
  logic               is_good, is_early, is_late, miss;
  logic               early_next, late_next, err_inc;

  // Interval classification of the current cycle.
  always_comb begin
    d        = (ival == IVAL_MAX) ? IVAL_MAX : ival + 1'b1;
    classify = tick && !resync && (state == S_ACQ || state == S_LOCKED);
    is_good  = classify && (d >= D_LO) && (d <= D_HI);
    is_early = classify && (d < D_LO);
    is_late  = classify && (d > D_HI);
    miss     = !tick && (ival == D_HI) && (state != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_next;
      good_run <= good_next;
      bad_run  <= bad_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    good_next  = good_run;
    bad_next   = bad_run;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          state_next = S_ACQ;
          good_next  = '0;
        end
      end
      S_ACQ: begin
        if (is_good) begin
          good_next = good_run + 1'b1;
          if (int'(good_run) + 1 >= LOCK_CNT) begin
            state_next = S_LOCKED;
            bad_next   = '0;
          end
        end else if (is_early || is_late || miss) begin
          good_next = '0;
        end
      end
      S_LOCKED: begin
        if (is_good) begin
          bad_next = '0;
        end else if (is_early || is_late || miss) begin
          bad_next = bad_run + 1'b1;
          if (int'(bad_run) + 1 >= FAULT_CNT)
            state_next = S_FAULT;
        end
      end
      S_FAULT: begin
        if (tick) begin
          state_next = S_ACQ;
          good_next  = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Error pulses are only reported while locked.
  always_comb begin
    early_next = (state == S_LOCKED) && is_early;
    late_next  = (state == S_LOCKED) && (is_late || miss);
    err_inc    = early_next || late_next;
  end

  // Interval counter, resync flag and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ival        <= '0;
      resync      <= 1'b0;
      err_cnt     <= '0;
      last_period <= '0;
      early       <= 1'b0;
      late        <= 1'b0;
      locked      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      if (tick) begin
        ival   <= '0;
        resync <= 1'b0;
      end else if (miss) begin
        ival   <= REARM;
        resync <= 1'b1;
      end else if (ival != IVAL_MAX) begin
        ival <= ival + 1'b1;
      end

      if (classify)
        last_period <= d;

      if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      early  <= early_next;
      late   <= late_next;
      locked <= (state_next == S_LOCKED);
      fault  <= (state_next == S_FAULT);
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor: table of tick spacings with
// hand-computed results, plus missing-tick and async-reset sequences.
module tb_tick_period_monitor;

  localparam int CBITS  = 12;
  localparam int ECBITS = 8;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              locked, fault, early, late;
  logic [ECBITS-1:0] err_cnt;
  logic [CBITS-1:0]  last_period;

  int checks   = 0;
  int failures = 0;
  int n_early  = 0;
  int n_late   = 0;

  tick_period_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .locked      (locked),
    .fault       (fault),
    .early       (early),
    .late        (late),
    .err_cnt     (err_cnt),
    .last_period (last_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (early) n_early++;
    if (late)  n_late++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tick is sampled on the next edge; returns #1 after that edge.
  task automatic send_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic gap_tick(input int gap);
    idle(gap - 1);
    send_tick();
  endtask

  typedef struct {
    int gap;
    bit e_early;
    bit e_late;
    bit e_locked;
    bit e_fault;
    int e_err;
    int e_lp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int e0, l0;
    // gap    early late lock fault err  last_period
    vecs[0]  = '{10,   0, 0, 0, 0, 0, 0};     // IDLE -> ACQ, unclassified
    vecs[1]  = '{1251, 0, 0, 0, 0, 0, 1251};
    vecs[2]  = '{1251, 0, 0, 0, 0, 0, 1251};
    vecs[3]  = '{1251, 0, 0, 1, 0, 0, 1251};  // third good interval locks
    vecs[4]  = '{1251, 0, 0, 1, 0, 0, 1251};
    vecs[5]  = '{1240, 1, 0, 1, 0, 1, 1240};
    vecs[6]  = '{1251, 0, 0, 1, 0, 1, 1251};  // clears bad_run
    vecs[7]  = '{1253, 0, 0, 1, 0, 1, 1253};  // upper edge of window
    vecs[8]  = '{1254, 0, 1, 1, 0, 2, 1254};  // late tick beats the miss
    vecs[9]  = '{1251, 0, 0, 1, 0, 2, 1251};
    vecs[10] = '{1,    1, 0, 1, 0, 3, 1};
    vecs[11] = '{1,    1, 0, 0, 1, 4, 1};     // second error -> FAULT
    vecs[12] = '{1251, 0, 0, 0, 0, 4, 1};     // resync tick, unclassified
    vecs[13] = '{1251, 0, 0, 0, 0, 4, 1251};
    vecs[14] = '{1251, 0, 0, 0, 0, 4, 1251};
    vecs[15] = '{1251, 0, 0, 1, 0, 4, 1251};

    rst  = 1'b0;
    tick = 1'b0;
    idle(3);
    check("reset_locked", locked, 0);
    check("reset_fault", fault, 0);
    check("reset_early", early, 0);
    check("reset_late", late, 0);
    check("reset_err", err_cnt, 0);
    check("reset_lp", last_period, 0);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++) begin
      gap_tick(vecs[i].gap);
      check($sformatf("row%0d_early", i), early, vecs[i].e_early);
      check($sformatf("row%0d_late", i), late, vecs[i].e_late);
      check($sformatf("row%0d_locked", i), locked, vecs[i].e_locked);
      check($sformatf("row%0d_fault", i), fault, vecs[i].e_fault);
      check($sformatf("row%0d_err", i), err_cnt, vecs[i].e_err);
      check($sformatf("row%0d_lp", i), last_period, vecs[i].e_lp);
      if (i == 5) begin
        idle(1);
        check("early_one_cycle", early, 0);
        // Stay on the same grid: one cycle of the next gap already elapsed.
        vecs[6].gap = vecs[6].gap - 1;
      end
    end
    check("table_early_pulses", n_early, 3);
    check("table_late_pulses", n_late, 1);

    // Ticks stop while locked: misses at 1254, then 1251 cycles later.
    e0 = n_early;
    l0 = n_late;
    idle(1253);
    check("miss1_not_yet", late, 0);
    idle(1);
    check("miss1_late", late, 1);
    check("miss1_err", err_cnt, 5);
    check("miss1_locked", locked, 1);
    idle(1);
    check("miss1_one_cycle", late, 0);
    idle(1249);
    check("miss2_not_yet", late, 0);
    idle(1);
    check("miss2_late", late, 1);
    check("miss2_fault", fault, 1);
    check("miss2_locked", locked, 0);
    check("miss2_err", err_cnt, 6);
    idle(2000);
    check("fault_ignores_miss", n_late - l0, 2);
    check("fault_err_kept", err_cnt, 6);
    check("miss_no_early", n_early - e0, 0);

    // Resume ticks: leave FAULT on the first, relock after three intervals.
    send_tick();
    check("resume_fault", fault, 0);
    check("resume_locked", locked, 0);
    check("resume_lp", last_period, 1251);
    gap_tick(1251);
    gap_tick(1251);
    check("relock_not_yet", locked, 0);
    gap_tick(1251);
    check("relock_locked", locked, 1);
    check("relock_err", err_cnt, 6);

    // Asynchronous reset mid-interval, no clock edge in between.
    idle(100);
    #2 rst = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_err", err_cnt, 0);
    check("async_lp", last_period, 0);
    check("async_fault", fault, 0);
    idle(3);
    rst = 1'b1;
    idle(5);
    send_tick();
    check("post_reset_first_lp", last_period, 0);
    check("post_reset_first_locked", locked, 0);
    gap_tick(1251);
    check("post_reset_second_lp", last_period, 1251);
    check("post_reset_second_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
